mul_operand_sequencer: RTL and testbench

Byte-serial front/back end for the 8x8 combinational array multiplier. It collects operand A then operand B from an 8-bit valid/ready stream and holds both in registers that drive the multiplier. After a programmable settle time it samples the 16-bit product and returns it low byte first, then high byte, on an 8-bit valid/ready output stream. It sits between the top-level pin mapping and the multiplier array.

---
 rtl/mul_operand_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_mul_operand_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_operand_sequencer.sv
// mul_operand_sequencer
// Byte-serial front/back end for the 8x8 combinational array multiplier.
// It collects operand A and then operand B from an 8-bit valid/ready stream
// and holds both in registers that drive the array. After SETTLE_CYCLES it
// samples the 16-bit product and returns it low byte first, then high byte,
// on an 8-bit valid/ready stream.
//
// Optional feature: define MUL_SEQ_ACCUM_EN to add a 16-bit wrapping
// accumulator. Each product is added into it and the running sum is returned
// instead of the bare product. acc_clr zeroes it. When acc_clr coincides
// with a capture, the sum restarts from that product. Without the macro,
// acc_clr is ignored and no accumulator register exists.
//
// All outputs are registers. They are updated together with the state, so
// no input reaches an output combinationally.

module mul_operand_sequencer #(
    // Cycles from operand B registering to the product being sampled (1..15)
    parameter int SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [7:0]  mul_a,
    output logic [7:0]  mul_b,
    input  logic [15:0] mul_p,
    input  logic        acc_clr,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_hi,
    output logic        busy
);

    typedef enum logic [2:0] {
        ST_LOAD_A  = 3'd0,
        ST_LOAD_B  = 3'd1,
        ST_SETTLE  = 3'd2,
        ST_SEND_LO = 3'd3,
        ST_SEND_HI = 3'd4
    } state_t;

    // Value loaded into the settle counter when operand B is accepted
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      state_r;
    logic [3:0]  cnt_r;
    logic [15:0] res_r;
    logic [7:0]  mul_a_r;
    logic [7:0]  mul_b_r;
    logic [7:0]  out_data_r;
    logic        in_ready_r;
    logic        out_valid_r;
    logic        out_hi_r;
    logic        busy_r;

    logic        in_xfer_s;
    logic        out_xfer_s;
    logic        capture_now_s;
    logic [15:0] cap_val_s;

    assign in_xfer_s     = in_valid & in_ready_r;
    assign out_xfer_s    = out_valid_r & out_ready;
    assign capture_now_s = (state_r == ST_SETTLE) && (cnt_r == 4'd0);

`ifdef MUL_SEQ_ACCUM_EN
    logic [15:0] acc_r;

    // Value captured into res: a clear on the capture edge restarts the sum from this product
    always_comb begin
        cap_val_s = 16'h0000;
        if (acc_clr) begin
            cap_val_s = mul_p;
        end else begin
            cap_val_s = acc_r + mul_p;
        end
    end

    // Running accumulator: follows each capture, zeroed by acc_clr otherwise
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_r <= 16'h0000;
        end else if (capture_now_s) begin
            acc_r <= cap_val_s;
        end else if (acc_clr) begin
            acc_r <= 16'h0000;
        end else begin
            acc_r <= acc_r;
        end
    end
`else
    logic unused_acc_clr_s;

    // Without the accumulator the bare product is captured and acc_clr has no effect
    always_comb begin
        cap_val_s        = 16'h0000;
        unused_acc_clr_s = 1'b0;
        if (1'b1) begin
            cap_val_s        = mul_p;
            unused_acc_clr_s = acc_clr;
        end else begin
            cap_val_s        = 16'h0000;
            unused_acc_clr_s = 1'b0;
        end
    end
`endif

    // Sequencer FSM: operand capture, settle countdown, byte return, and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_LOAD_A;
            cnt_r       <= 4'd0;
            res_r       <= 16'h0000;
            mul_a_r     <= 8'h00;
            mul_b_r     <= 8'h00;
            out_data_r  <= 8'h00;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_hi_r    <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            case (state_r)
                ST_LOAD_A: begin
                    if (in_xfer_s) begin
                        mul_a_r <= in_data;
                        busy_r  <= 1'b1;
                        state_r <= ST_LOAD_B;
                    end else begin
                        state_r <= ST_LOAD_A;
                    end
                end
                ST_LOAD_B: begin
                    if (in_xfer_s) begin
                        mul_b_r    <= in_data;
                        cnt_r      <= SETTLE_LOAD;
                        in_ready_r <= 1'b0;
                        state_r    <= ST_SETTLE;
                    end else begin
                        state_r <= ST_LOAD_B;
                    end
                end
                ST_SETTLE: begin
                    if (capture_now_s) begin
                        res_r       <= cap_val_s;
                        out_data_r  <= cap_val_s[7:0];
                        out_hi_r    <= 1'b0;
                        out_valid_r <= 1'b1;
                        state_r     <= ST_SEND_LO;
                    end else begin
                        cnt_r <= cnt_r - 4'd1;
                    end
                end
                ST_SEND_LO: begin
                    if (out_xfer_s) begin
                        out_data_r <= res_r[15:8];
                        out_hi_r   <= 1'b1;
                        state_r    <= ST_SEND_HI;
                    end else begin
                        state_r <= ST_SEND_LO;
                    end
                end
                ST_SEND_HI: begin
                    if (out_xfer_s) begin
                        out_data_r  <= 8'h00;
                        out_hi_r    <= 1'b0;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                        state_r     <= ST_LOAD_A;
                    end else begin
                        state_r <= ST_SEND_HI;
                    end
                end
                default: begin
                    // Unreachable encoding: fall back to an idle, consistent state
                    cnt_r       <= 4'd0;
                    out_data_r  <= 8'h00;
                    out_hi_r    <= 1'b0;
                    out_valid_r <= 1'b0;
                    in_ready_r  <= 1'b1;
                    busy_r      <= 1'b0;
                    state_r     <= ST_LOAD_A;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = out_valid_r;
    assign out_hi    = out_hi_r;
    assign out_data  = out_data_r;
    assign busy      = busy_r;
    assign mul_a     = mul_a_r;
    assign mul_b     = mul_b_r;

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Testbench for mul_operand_sequencer: a transaction-level model predicts
// operands, handshake levels and the returned byte stream, checked every cycle,
// plus directed vectors with hand-computed results.

module tb_mul_operand_sequencer;

    localparam int S = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  mul_a;
    logic [7:0]  mul_b;
    logic [15:0] mul_p;
    logic        acc_clr = 1'b0;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_hi;
    logic        busy;

    int tests = 0;
    int fails = 0;

    mul_operand_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
        .acc_clr(acc_clr),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_hi(out_hi), .busy(busy)
    );

    // Stand-in for the combinational array
    assign mul_p = 16'(mul_a) * 16'(mul_b);

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0]  m_a = 8'h00;
    logic [7:0]  m_b = 8'h00;
    bit          m_have_a = 1'b0;
    bit          m_pending = 1'b0;
    int          m_cap_cyc = 0;
    logic [15:0] m_acc = 16'h0000;
    logic [8:0]  exp_q[$];   // {hi flag, byte} still to be returned
    logic [7:0]  rx_q[$];    // bytes actually handed over by the DUT
    int          cyc = 0;
    bit          m_accepting;
    logic [15:0] m_prod;
    logic [15:0] m_val;

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_a = 8'h00; m_b = 8'h00; m_have_a = 1'b0; m_pending = 1'b0;
                m_acc = 16'h0000; exp_q.delete();
            end else begin
                cyc++;
                // Input is taken only when no product is in flight or unsent
                m_accepting = !m_pending && (exp_q.size() == 0);
                if (exp_q.size() != 0 && out_ready) begin
                    rx_q.push_back(out_data);
                    void'(exp_q.pop_front());
                end
                if (m_pending && cyc == m_cap_cyc) begin
                    m_prod = 16'(m_a) * 16'(m_b);
`ifdef MUL_SEQ_ACCUM_EN
                    if (acc_clr) m_acc = m_prod;
                    else         m_acc = m_acc + m_prod;
                    m_val = m_acc;
`else
                    m_val = m_prod;
`endif
                    exp_q.push_back({1'b0, m_val[7:0]});
                    exp_q.push_back({1'b1, m_val[15:8]});
                    m_pending = 1'b0;
                end
`ifdef MUL_SEQ_ACCUM_EN
                else if (acc_clr) m_acc = 16'h0000;
`endif
                if (m_accepting && in_valid) begin
                    if (!m_have_a) begin
                        m_a = in_data; m_have_a = 1'b1;
                    end else begin
                        m_b = in_data; m_have_a = 1'b0; m_pending = 1'b1;
                        m_cap_cyc = cyc + S;
                    end
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    initial begin
        forever begin
            @(negedge clk);
            check("in_ready", {31'd0, in_ready}, {31'd0, (!m_pending && exp_q.size() == 0)});
            check("busy", {31'd0, busy}, {31'd0, (m_have_a || m_pending || exp_q.size() != 0)});
            check("out_valid", {31'd0, out_valid}, {31'd0, (exp_q.size() != 0)});
            check("mul_a", {24'd0, mul_a}, {24'd0, m_a});
            check("mul_b", {24'd0, mul_b}, {24'd0, m_b});
            if (exp_q.size() != 0) begin
                check("out_data", {24'd0, out_data}, {24'd0, exp_q[0][7:0]});
                check("out_hi", {31'd0, out_hi}, {31'd0, exp_q[0][8]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called at a negedge; returns at the negedge after the byte was taken
    task automatic put_byte(input logic [7:0] d);
        int guard;
        guard = 0;
        in_data  = d;
        in_valid = 1'b1;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) begin
            tests++; fails++;
            $display("FAIL put_byte timeout: in_ready stayed 0 required 1");
        end
        @(negedge clk);
    endtask

    task automatic wait_idle();
        int guard;
        guard = 0;
        while ((busy || exp_q.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        check("idle_busy", {31'd0, busy}, 32'd0);
    endtask

    task automatic clr_acc();
        acc_clr = 1'b1;
        @(negedge clk);
        acc_clr = 1'b0;
    endtask

    task automatic check_rx(input int idx, input logic [7:0] exp);
        if (idx < rx_q.size()) begin
            check($sformatf("rx[%0d]", idx), {24'd0, rx_q[idx]}, {24'd0, exp});
        end else begin
            tests++; fails++;
            $display("FAIL rx[%0d]: got no byte required 0x%0h", idx, exp);
        end
    endtask

    int          g;
    int          c0;
    logic [7:0]  e_lo;
    logic [7:0]  e_hi;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data", {24'd0, out_data}, 32'h00);
        check("rst_out_hi", {31'd0, out_hi}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_mul_a", {24'd0, mul_a}, 32'h00);
        check("rst_mul_b", {24'd0, mul_b}, 32'h00);

        // Single product 0x0F * 0x11 = 0x00FF, with latency
        clr_acc();
        rx_q.delete();
        put_byte(8'h0F);
        put_byte(8'h11);
        in_valid = 1'b0;
        g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        check("latency_edges", g, S);
        wait_idle();
        check_rx(0, 8'hFF);
        check_rx(1, 8'h00);

        // Max operands 0xFF * 0xFF = 0xFE01
        clr_acc();
        rx_q.delete();
        put_byte(8'hFF);
        put_byte(8'hFF);
        in_valid = 1'b0;
        wait_idle();
        check_rx(0, 8'h01);
        check_rx(1, 8'hFE);

        // Backpressure with in_valid held: 0x12 * 0x34 = 0x03A8
        clr_acc();
        rx_q.delete();
        out_ready = 1'b0;
        put_byte(8'h12);
        put_byte(8'h34);
        in_data = 8'h55;
        g = 0;
        while (!out_valid && g < 50) begin
            @(negedge clk);
            g++;
        end
        for (int i = 0; i < 5; i++) begin
            check("stall_out_data", {24'd0, out_data}, 32'hA8);
            check("stall_out_hi", {31'd0, out_hi}, 32'd0);
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            check("stall_mul_a", {24'd0, mul_a}, 32'h12);
            check("stall_mul_b", {24'd0, mul_b}, 32'h34);
            @(negedge clk);
        end
        out_ready = 1'b1;
        in_valid  = 1'b0;
        wait_idle();
        check_rx(0, 8'hA8);
        check_rx(1, 8'h03);

        // Reset during SETTLE, then 0x02 * 0x03 = 0x0006
        clr_acc();
        rx_q.delete();
        put_byte(8'h40);
        put_byte(8'h50);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_mul_a", {24'd0, mul_a}, 32'h00);
        check("midrst_mul_b", {24'd0, mul_b}, 32'h00);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        put_byte(8'h02);
        put_byte(8'h03);
        in_valid = 1'b0;
        wait_idle();
        check_rx(0, 8'h06);
        check_rx(1, 8'h00);

        // Two passes of 0xFF * 0xFF, then clear and 0x02 * 0x02
        clr_acc();
        rx_q.delete();
        for (int p = 0; p < 2; p++) begin
            put_byte(8'hFF);
            put_byte(8'hFF);
            in_valid = 1'b0;
            wait_idle();
        end
        clr_acc();
        put_byte(8'h02);
        put_byte(8'h02);
        in_valid = 1'b0;
        wait_idle();
`ifdef MUL_SEQ_ACCUM_EN
        e_lo = 8'h02; e_hi = 8'hFC;
`else
        e_lo = 8'h01; e_hi = 8'hFE;
`endif
        check_rx(0, 8'h01);
        check_rx(1, 8'hFE);
        check_rx(2, e_lo);
        check_rx(3, e_hi);
        check_rx(4, 8'h04);
        check_rx(5, 8'h00);

        // Back-to-back: 0x10 * 0x10 then 0x07 * 0x09, with throughput check
        clr_acc();
        rx_q.delete();
        put_byte(8'h10);
        c0 = cyc;
        put_byte(8'h10);
        put_byte(8'h07);
        check("throughput_cycles", cyc - c0, 2 + S + 2);
        put_byte(8'h09);
        in_valid = 1'b0;
        wait_idle();
`ifdef MUL_SEQ_ACCUM_EN
        e_hi = 8'h01;
`else
        e_hi = 8'h00;
`endif
        check_rx(0, 8'h00);
        check_rx(1, 8'h01);
        check_rx(2, 8'h3F);
        check_rx(3, e_hi);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
